tr_switch_sequencer: RTL

//  Break-before-make sequencer for the LNA transmit/receive switch; drives EnableTransmit/EnableReceive.

---
 rtl/trsw_pkg.sv | 52 +++++
 rtl/trsw_interval_timer.sv | 28 ++
 rtl/tr_switch_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/trsw_pkg.sv
// Shared state encoding, output bundle and default timing for the TX/RX switch sequencer.
package trsw_pkg;

  // The encodings are visible on SwState for debug, so they are fixed here.
  typedef enum logic [2:0] {
    SW_RX_SETTLE   = 3'd0,
    SW_RX_ACTIVE   = 3'd1,
    SW_GUARD_TO_TX = 3'd2,
    SW_TX_SETTLE   = 3'd3,
    SW_TX_ACTIVE   = 3'd4,
    SW_GUARD_TO_RX = 3'd5
  } sw_state_t;

  typedef struct packed {
    logic en_tx;
    logic en_rx;
    logic tx_grant;
    logic rx_valid;
  } sw_outputs_t;

  localparam int DEFAULT_GUARD_CYCLES  = 4;
  localparam int DEFAULT_SETTLE_CYCLES = 8;
  localparam int DEFAULT_TX_MAX_CYCLES = 4096;
  localparam int DEFAULT_CNT_W         = 13;

  // Output levels held while resident in a state; only one enable is ever set.
  function automatic sw_outputs_t state_outputs(input sw_state_t s);
    sw_outputs_t o;
    o = '0;
    case (s)
      SW_RX_SETTLE: o.en_rx = 1'b1;
      SW_RX_ACTIVE: begin
        o.en_rx    = 1'b1;
        o.rx_valid = 1'b1;
      end
      SW_TX_SETTLE: o.en_tx = 1'b1;
      SW_TX_ACTIVE: begin
        o.en_tx    = 1'b1;
        o.tx_grant = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/trsw_interval_timer.sv
// Interval counter shared by guard, settle and watchdog intervals.
// Cleared on state entry, counts up and saturates at the terminal value.
module trsw_interval_timer #(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] last,
  output logic             done
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (!done) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Holding at the terminal value keeps the count from wrapping in long states.
  assign done = (count_reg == last);

endmodule

// File: rtl/tr_switch_sequencer.sv
// Break-before-make sequencer driving the LNA EnableTransmit/EnableReceive pins.
// Optional TX watchdog is built only when TRSW_WATCHDOG_EN is defined.
module tr_switch_sequencer
  import trsw_pkg::*;
#(
  parameter int GUARD_CYCLES  = DEFAULT_GUARD_CYCLES,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int TX_MAX_CYCLES = DEFAULT_TX_MAX_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       TxRequest,
  input  logic       TxDone,
  output logic       TxGrant,
  output logic       RxValid,
  output logic       EnableTransmit,
  output logic       EnableReceive,
  output logic [2:0] SwState,
  output logic       WatchdogTrip
);

  generate
    if (GUARD_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_timing
      $error("tr_switch_sequencer: GUARD_CYCLES and SETTLE_CYCLES must be >= 1");
    end
    if (max3(GUARD_CYCLES, SETTLE_CYCLES, TX_MAX_CYCLES) > (1 << CNT_W)) begin : g_bad_width
      $error("tr_switch_sequencer: CNT_W too narrow for configured intervals");
    end
  endgenerate

  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  sw_state_t        state_reg;
  sw_state_t        state_next;
  sw_outputs_t      outs_reg;
  sw_outputs_t      outs_next;
  logic [CNT_W-1:0] interval_last;
  logic             interval_clear;
  logic             interval_done;
  logic             tx_hold_off;

`ifdef TRSW_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_MAX_CYCLES - 1);
  logic wd_expire;
  logic trip_reg;
  logic hold_off_reg;
`endif

  trsw_interval_timer #(
    .CNT_W (CNT_W)
  ) u_interval_timer (
    .clk   (Clock),
    .rst_n (ResetN),
    .clear (interval_clear),
    .last  (interval_last),
    .done  (interval_done)
  );

  // State and output registers; reset lands directly in RX_SETTLE with only RX enabled.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_reg <= SW_RX_SETTLE;
      outs_reg  <= state_outputs(SW_RX_SETTLE);
    end else begin
      state_reg <= state_next;
      outs_reg  <= outs_next;
    end
  end

  always_comb begin
    state_next = state_reg;
`ifdef TRSW_WATCHDOG_EN
    wd_expire  = 1'b0;
`endif
    case (state_reg)
      SW_RX_SETTLE: begin
        if (interval_done) state_next = SW_RX_ACTIVE;
      end
      SW_RX_ACTIVE: begin
        if (TxRequest && !tx_hold_off) state_next = SW_GUARD_TO_TX;
      end
      SW_GUARD_TO_TX: begin
        if (!TxRequest) state_next = SW_GUARD_TO_RX;
        else if (interval_done) state_next = SW_TX_SETTLE;
      end
      SW_TX_SETTLE: begin
        if (!TxRequest) state_next = SW_GUARD_TO_RX;
        else if (interval_done) state_next = SW_TX_ACTIVE;
      end
      SW_TX_ACTIVE: begin
        if (TxDone || !TxRequest) begin
          state_next = SW_GUARD_TO_RX;
`ifdef TRSW_WATCHDOG_EN
        end else if (interval_done) begin
          state_next = SW_GUARD_TO_RX;
          wd_expire  = 1'b1;
`endif
        end
      end
      SW_GUARD_TO_RX: begin
        if (interval_done) state_next = SW_RX_SETTLE;
      end
      default: state_next = SW_RX_SETTLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so every enable changes on the entry edge.
  always_comb begin
    outs_next = state_outputs(state_next);
  end

  always_comb begin
    interval_last = '1;
    case (state_reg)
      SW_RX_SETTLE, SW_TX_SETTLE:     interval_last = SETTLE_LAST;
      SW_GUARD_TO_TX, SW_GUARD_TO_RX: interval_last = GUARD_LAST;
`ifdef TRSW_WATCHDOG_EN
      SW_TX_ACTIVE:                   interval_last = TX_LAST;
`endif
      default:                        interval_last = '1;
    endcase
  end

  assign interval_clear = (state_next != state_reg);

`ifdef TRSW_WATCHDOG_EN
  // After a trip the request must be seen low once before another TX is accepted.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      trip_reg     <= 1'b0;
      hold_off_reg <= 1'b0;
    end else begin
      if (wd_expire) trip_reg <= 1'b1;
      if (wd_expire) hold_off_reg <= 1'b1;
      else if (!TxRequest) hold_off_reg <= 1'b0;
    end
  end

  assign WatchdogTrip = trip_reg;
  assign tx_hold_off  = hold_off_reg;
`else
  assign WatchdogTrip = 1'b0;
  assign tx_hold_off  = 1'b0;
`endif

  assign EnableTransmit = outs_reg.en_tx;
  assign EnableReceive  = outs_reg.en_rx;
  assign TxGrant        = outs_reg.tx_grant;
  assign RxValid        = outs_reg.rx_valid;
  assign SwState        = state_reg;

endmodule
